// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI target pin and parallel word bundle
interface spi_slave_if #(
    parameter int FRAME_SIZE = 8
);
    logic                  cpol;
    logic                  cpha;
    logic                  sck;
    logic                  cs;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic [FRAME_SIZE-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [FRAME_SIZE-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_underrun;
    logic                  frame_err;
    logic                  busy;

    modport slave (
        input  cpol, cpha, sck, cs, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy
    );

    modport master (
        output cpol, cpha, sck, cs, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy
    );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled SPI target, all CPOL/CPHA modes, MSB first
module spi_slave #(
    parameter int FRAME_SIZE  = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic       clk,
    input logic       rst,
    spi_slave_if.slave bus
);
    localparam int CW = $clog2(FRAME_SIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(FRAME_SIZE - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_d, cs_d;
    logic                   cpol_l, cpha_l;
    logic [FRAME_SIZE-1:0]  rx_shift, tx_shift, hold_data, rx_data_q;
    logic                   hold_full, reload_pending;
    logic [CW-1:0]          bit_cnt;
    logic                   miso_q, miso_oe_q, rx_valid_q, underrun_q, frame_err_q;
    logic                   start, stop;

    wire sck_s  = sck_sync[SYNC_STAGES-1];
    wire cs_s   = cs_sync[SYNC_STAGES-1];
    wire mosi_s = mosi_sync[SYNC_STAGES-1];

    wire sck_rise    = sck_s & ~sck_d;
    wire sck_fall    = ~sck_s & sck_d;
    wire cs_rise     = cs_s & ~cs_d;
    wire cs_fall     = ~cs_s & cs_d;
    wire lead_edge   = cpol_l ? sck_fall : sck_rise;
    wire trail_edge  = cpol_l ? sck_rise : sck_fall;
    wire sample_edge = cpha_l ? trail_edge : lead_edge;
    wire shift_edge  = cpha_l ? lead_edge : trail_edge;
    wire completing  = sample_edge && (bit_cnt == LAST);
    wire wr          = bus.tx_valid && !hold_full;

    wire [FRAME_SIZE-1:0] load_word = hold_full ? hold_data : '0;
    wire [FRAME_SIZE-1:0] rx_next   = {rx_shift[FRAME_SIZE-2:0], mosi_s};

    // Bring the asynchronous SPI pins into the clk domain and keep one-clk-old copies for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Select on cs rising while idle, deselect on cs falling while active
    always_comb begin
        state_next = state;
        start      = 1'b0;
        stop       = 1'b0;
        case (state)
            IDLE: begin
                if (cs_rise) begin
                    state_next = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_fall) begin
                    state_next = IDLE;
                    stop       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift registers, holding register and status pulses; a write is applied last so it
    // lands in the (just emptied) holding register for the following frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpol_l         <= 1'b0;
            cpha_l         <= 1'b0;
            rx_shift       <= '0;
            tx_shift       <= '0;
            hold_data      <= '0;
            hold_full      <= 1'b0;
            reload_pending <= 1'b0;
            bit_cnt        <= '0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            miso_q         <= 1'b0;
            miso_oe_q      <= 1'b0;
            underrun_q     <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (start) begin
                cpol_l         <= bus.cpol;
                cpha_l         <= bus.cpha;
                bit_cnt        <= '0;
                rx_shift       <= '0;
                reload_pending <= 1'b0;
                miso_oe_q      <= 1'b1;
                underrun_q     <= !hold_full;
                hold_full      <= 1'b0;
                if (!bus.cpha) begin
                    miso_q   <= load_word[FRAME_SIZE-1];
                    tx_shift <= {load_word[FRAME_SIZE-2:0], 1'b0};
                end else begin
                    miso_q   <= 1'b0;
                    tx_shift <= load_word;
                end
            end else if (state == ACTIVE) begin
                if (sample_edge) begin
                    rx_shift <= rx_next;
                    if (completing) begin
                        bit_cnt        <= '0;
                        rx_data_q      <= rx_next;
                        rx_valid_q     <= 1'b1;
                        reload_pending <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (shift_edge) begin
                    if (reload_pending) begin
                        reload_pending <= 1'b0;
                        underrun_q     <= !hold_full;
                        hold_full      <= 1'b0;
                        miso_q         <= load_word[FRAME_SIZE-1];
                        tx_shift       <= {load_word[FRAME_SIZE-2:0], 1'b0};
                    end else begin
                        miso_q   <= tx_shift[FRAME_SIZE-1];
                        tx_shift <= {tx_shift[FRAME_SIZE-2:0], 1'b0};
                    end
                end
                if (stop) begin
                    miso_oe_q      <= 1'b0;
                    miso_q         <= 1'b0;
                    reload_pending <= 1'b0;
                    bit_cnt        <= '0;
                    frame_err_q    <= (bit_cnt != '0) && !completing;
                end
            end
            if (wr) begin
                hold_data <= bus.tx_data;
                hold_full <= 1'b1;
            end
        end
    end

    assign bus.miso        = miso_q;
    assign bus.miso_oe     = miso_oe_q;
    assign bus.tx_ready    = !hold_full;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = underrun_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.busy        = (state == ACTIVE);
endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - directed self-checking bench for spi_slave
module tb_spi_slave;
    localparam int HALF = 60;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int         rx_cnt = 0;
    int         ur_cnt = 0;
    int         fe_cnt = 0;
    logic [7:0] rx_log [0:31];

    spi_slave_if #(.FRAME_SIZE(8)) bus ();

    spi_slave #(.FRAME_SIZE(8), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_log[rx_cnt[4:0]] = bus.rx_data;
            rx_cnt = rx_cnt + 1;
        end
        if (bus.tx_underrun) ur_cnt = ur_cnt + 1;
        if (bus.frame_err)   fe_cnt = fe_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tx_write(input logic [7:0] d);
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    task automatic set_mode(input logic p, input logic h);
        bus.cpol = p;
        bus.cpha = h;
        bus.sck  = p;
        repeat (6) @(negedge clk);
    endtask

    task automatic xfer(input int nbits, input logic [15:0] mo, output logic [15:0] mi);
        mi       = '0;
        bus.sck  = bus.cpol;
        bus.mosi = bus.cpha ? 1'b0 : mo[nbits-1];
        bus.cs   = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            #HALF;
            bus.sck = ~bus.cpol;
            if (!bus.cpha) mi = {mi[14:0], bus.miso};
            else           bus.mosi = mo[nbits-1-i];
            #HALF;
            bus.sck = bus.cpol;
            if (!bus.cpha) bus.mosi = (i < nbits - 1) ? mo[nbits-2-i] : 1'b0;
            else           mi = {mi[14:0], bus.miso};
        end
        #HALF;
        bus.cs = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [15:0] mi;
        int r0, u0, f0;
        bus.cpol = 0; bus.cpha = 0; bus.sck = 0; bus.cs = 0; bus.mosi = 0;
        bus.tx_data = '0; bus.tx_valid = 0;
        repeat (3) @(negedge clk);
        check("rst_miso", 16'(bus.miso), 16'h0);
        check("rst_miso_oe", 16'(bus.miso_oe), 16'h0);
        check("rst_tx_ready", 16'(bus.tx_ready), 16'h1);
        check("rst_rx_data", 16'(bus.rx_data), 16'h0);
        check("rst_busy", 16'(bus.busy), 16'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: mode 0
        tx_write(8'hA5);
        check("t1_tx_ready_full", 16'(bus.tx_ready), 16'h0);
        r0 = rx_cnt;
        xfer(8, 16'h003C, mi);
        check("t1_rx_cnt", 16'(rx_cnt - r0), 16'd1);
        check("t1_rx_data", 16'(rx_log[r0[4:0]]), 16'h3C);
        check("t1_master_rx", mi & 16'h00FF, 16'h00A5);
        check("t1_tx_ready_back", 16'(bus.tx_ready), 16'h1);
        check("t1_miso_oe_off", 16'(bus.miso_oe), 16'h0);

        // 2: mode 3
        set_mode(1'b1, 1'b1);
        tx_write(8'h81);
        r0 = rx_cnt;
        xfer(8, 16'h007E, mi);
        check("t2_rx_cnt", 16'(rx_cnt - r0), 16'd1);
        check("t2_rx_data", 16'(rx_log[r0[4:0]]), 16'h7E);
        check("t2_master_rx", mi & 16'h00FF, 16'h0081);

        // 3: back-to-back frames in mode 0, second word written during the first frame
        set_mode(1'b0, 1'b0);
        tx_write(8'h11);
        r0 = rx_cnt;
        fork
            xfer(16, 16'hF00F, mi);
            begin
                #400;
                check("t3_tx_ready_mid", 16'(bus.tx_ready), 16'h1);
                tx_write(8'h22);
            end
        join
        check("t3_rx_cnt", 16'(rx_cnt - r0), 16'd2);
        check("t3_rx_first", 16'(rx_log[r0[4:0]]), 16'hF0);
        check("t3_rx_second", 16'(rx_log[5'(r0 + 1)]), 16'h0F);
        check("t3_master_rx", mi, 16'h1122);

        // 4: underrun in mode 3 (no reload edge follows the final sample)
        set_mode(1'b1, 1'b1);
        r0 = rx_cnt;
        u0 = ur_cnt;
        xfer(8, 16'h0055, mi);
        check("t4_underrun_cnt", 16'(ur_cnt - u0), 16'd1);
        check("t4_master_rx", mi & 16'h00FF, 16'h0000);
        check("t4_rx_data", 16'(rx_log[r0[4:0]]), 16'h55);

        // 5: cs drop after 5 bits, then a good frame
        set_mode(1'b0, 1'b0);
        r0 = rx_cnt;
        f0 = fe_cnt;
        xfer(5, 16'h0013, mi);
        check("t5_no_rx_valid", 16'(rx_cnt - r0), 16'd0);
        check("t5_frame_err", 16'(fe_cnt - f0), 16'd1);
        check("t5_miso_oe", 16'(bus.miso_oe), 16'h0);
        check("t5_rx_held", 16'(bus.rx_data), 16'h55);
        xfer(8, 16'h009C, mi);
        check("t5_rx_cnt", 16'(rx_cnt - r0), 16'd1);
        check("t5_rx_data", 16'(rx_log[r0[4:0]]), 16'h9C);
        check("t5_frame_err_once", 16'(fe_cnt - f0), 16'd1);

        // 6: reset in the middle of a frame
        tx_write(8'h5A);
        r0 = rx_cnt;
        f0 = fe_cnt;
        bus.mosi = 1'b1;
        bus.cs   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #HALF; bus.sck = 1'b1;
            #HALF; bus.sck = 1'b0;
        end
        #HALF;
        check("t6_busy_before", 16'(bus.busy), 16'h1);
        rst = 1'b1;
        #1;
        check("t6_rst_miso", 16'(bus.miso), 16'h0);
        check("t6_rst_miso_oe", 16'(bus.miso_oe), 16'h0);
        check("t6_rst_tx_ready", 16'(bus.tx_ready), 16'h1);
        check("t6_rst_rx_data", 16'(bus.rx_data), 16'h0);
        check("t6_rst_busy", 16'(bus.busy), 16'h0);
        bus.cs = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        xfer(8, 16'h00C3, mi);
        check("t6_rx_cnt", 16'(rx_cnt - r0), 16'd1);
        check("t6_rx_data", 16'(rx_log[r0[4:0]]), 16'hC3);
        check("t6_no_frame_err", 16'(fe_cnt - f0), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
